// File: rtl/pkt_sender_mb_pkg.sv
// Shared types and constants for the multi-beat TCP packet sender.
package pkt_sender_mb_pkg;
  localparam int DEF_DATA_W         = 512;
  localparam int DEF_BYTES          = DEF_DATA_W / 8;
  localparam int DEF_MAX_BEATS      = 16;
  localparam int DEF_FIFO_ADDR_BITS = 5;
  localparam int DEF_STATUS_ERR_BIT = 62;

  localparam int TUSER_SESS_LSB = 0;
  localparam int TUSER_LEN_LSB  = 16;
  localparam int TUSER_FIELD_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DROP = 2'd2
  } eg_state_t;
endpackage

// File: rtl/pkt_sender_mb_if.sv
// Stream bundle between the result formatter, the TCP stack and the packet sender.
interface pkt_sender_mb_if
  import pkt_sender_mb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();
  logic [DATA_W-1:0]   pkt_rx_TDATA;
  logic [31:0]         pkt_rx_TUSER;
  logic                pkt_rx_TLAST;
  logic                pkt_rx_TVALID;
  logic                pkt_rx_TREADY;

  logic [63:0]         s_axis_tx_status_TDATA;
  logic                s_axis_tx_status_TVALID;
  logic                s_axis_tx_status_TREADY;

  logic [31:0]         m_axis_tx_metadata_TDATA;
  logic                m_axis_tx_metadata_TVALID;
  logic                m_axis_tx_metadata_TREADY;

  logic [DATA_W-1:0]   m_axis_tx_data_TDATA;
  logic [DATA_W/8-1:0] m_axis_tx_data_TKEEP;
  logic                m_axis_tx_data_TLAST;
  logic                m_axis_tx_data_TVALID;
  logic                m_axis_tx_data_TREADY;

  modport slave (
    input  pkt_rx_TDATA, pkt_rx_TUSER, pkt_rx_TLAST, pkt_rx_TVALID,
    output pkt_rx_TREADY,
    input  s_axis_tx_status_TDATA, s_axis_tx_status_TVALID,
    output s_axis_tx_status_TREADY,
    output m_axis_tx_metadata_TDATA, m_axis_tx_metadata_TVALID,
    input  m_axis_tx_metadata_TREADY,
    output m_axis_tx_data_TDATA, m_axis_tx_data_TKEEP, m_axis_tx_data_TLAST,
    output m_axis_tx_data_TVALID,
    input  m_axis_tx_data_TREADY
  );

  modport master (
    output pkt_rx_TDATA, pkt_rx_TUSER, pkt_rx_TLAST, pkt_rx_TVALID,
    input  pkt_rx_TREADY,
    output s_axis_tx_status_TDATA, s_axis_tx_status_TVALID,
    input  s_axis_tx_status_TREADY,
    input  m_axis_tx_metadata_TDATA, m_axis_tx_metadata_TVALID,
    output m_axis_tx_metadata_TREADY,
    input  m_axis_tx_data_TDATA, m_axis_tx_data_TKEEP, m_axis_tx_data_TLAST,
    input  m_axis_tx_data_TVALID,
    output m_axis_tx_data_TREADY
  );
endinterface

// File: rtl/nukv_fifogen.sv
// First-word-fall-through FIFO of 2**ADDR_BITS entries; head is valid the cycle after a push.
module nukv_fifogen #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [DATA_SIZE-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready
);
  localparam int                 DEPTH    = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0] CNT_ONE  = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);

  logic [DATA_SIZE-1:0] mem_r [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_r;
  logic [ADDR_BITS-1:0] rd_ptr_r;
  logic [ADDR_BITS:0]   count_r;
  logic                 push_s;
  logic                 pop_s;

  assign s_axis_tready = (count_r != FULL_CNT);
  assign m_axis_tvalid = (count_r != {(ADDR_BITS + 1){1'b0}});
  assign m_axis_tdata  = mem_r[rd_ptr_r];
  assign push_s        = s_axis_tvalid & s_axis_tready;
  assign pop_s         = m_axis_tvalid & m_axis_tready;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= s_axis_tdata;
    end
  end

  // Pointers and occupancy; push and pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {ADDR_BITS{1'b0}};
      rd_ptr_r <= {ADDR_BITS{1'b0}};
      count_r  <= {(ADDR_BITS + 1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/pkt_sender_mb.sv
// Multi-beat TCP packet sender: emits metadata per packet, holds payload until the
// stack returns tx status, then forwards it with TKEEP/TLAST or drains it on error.
module pkt_sender_mb
  import pkt_sender_mb_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int MAX_BEATS      = DEF_MAX_BEATS,
  parameter int FIFO_ADDR_BITS = DEF_FIFO_ADDR_BITS,
  parameter int STATUS_ERR_BIT = DEF_STATUS_ERR_BIT
) (
  input  logic          clk,
  input  logic          rst_n,
  pkt_sender_mb_if.slave bus,
  output logic [31:0]   tx_pkt_cnt,
  output logic [31:0]   drop_pkt_cnt,
  output logic [31:0]   bad_len_cnt
);
  localparam int          BYTES   = DATA_W / 8;
  localparam int          REM_W   = $clog2(BYTES);
  localparam logic [16:0] MAX_LEN = 17'(MAX_BEATS * BYTES);

  logic             in_first_r;
  logic             bad_pkt_r;
  logic [15:0]      rx_len_s;
  logic             len_ok_s;
  logic             rx_ready_s;
  logic             rx_fire_s;
  logic             keep_beat_s;
  logic             toss_beat_s;
  logic             meta_push_s;

  logic             pay_in_rdy_s;
  logic             meta_in_rdy_s;
  logic             len_in_rdy_s;
  logic             st_in_rdy_s;
  logic [DATA_W:0]  pay_head_s;
  logic             pay_valid_s;
  logic             pay_pop_s;
  logic             pay_last_s;
  logic [31:0]      meta_head_s;
  logic             meta_valid_s;
  logic [15:0]      len_head_s;
  logic             len_valid_s;
  logic             len_pop_s;
  logic             st_head_s;
  logic             st_valid_s;
  logic             st_pop_s;

  eg_state_t        state_r;
  eg_state_t        state_nxt_s;
  logic [15:0]      len_r;
  logic             data_valid_s;
  logic             tx_inc_s;
  logic             drop_inc_s;
  logic             status_unused_s;

  function automatic logic [BYTES-1:0] last_keep(input logic [REM_W-1:0] rem);
    logic [BYTES-1:0] k;
    for (int i = 0; i < BYTES; i++) begin
      k[i] = (rem == {REM_W{1'b0}}) || (i < int'(rem));
    end
    return k;
  endfunction

  assign rx_len_s        = bus.pkt_rx_TUSER[TUSER_LEN_LSB +: TUSER_FIELD_W];
  assign len_ok_s        = (rx_len_s != 16'd0) && ({1'b0, rx_len_s} <= MAX_LEN);
  assign status_unused_s = ^{bus.s_axis_tx_status_TDATA, len_r[15:REM_W]};

  // Ingress ready: illegal packets are swallowed unconditionally, first beats also need meta/len room.
  always_comb begin
    rx_ready_s = 1'b0;
    if (!rst_n) begin
      rx_ready_s = 1'b0;
    end else if (in_first_r) begin
      if (len_ok_s) rx_ready_s = pay_in_rdy_s & meta_in_rdy_s & len_in_rdy_s;
      else          rx_ready_s = 1'b1;
    end else if (bad_pkt_r) begin
      rx_ready_s = 1'b1;
    end else begin
      rx_ready_s = pay_in_rdy_s;
    end
  end

  assign rx_fire_s         = bus.pkt_rx_TVALID & rx_ready_s;
  assign keep_beat_s       = rx_fire_s & (in_first_r ? len_ok_s : ~bad_pkt_r);
  assign toss_beat_s       = rx_fire_s & ~keep_beat_s;
  assign meta_push_s       = keep_beat_s & in_first_r;
  assign bus.pkt_rx_TREADY = rx_ready_s;

  // Packet framing state: TLAST re-arms first-beat detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_first_r <= 1'b1;
      bad_pkt_r  <= 1'b0;
    end else if (rx_fire_s) begin
      if (bus.pkt_rx_TLAST) begin
        in_first_r <= 1'b1;
        bad_pkt_r  <= 1'b0;
      end else if (in_first_r) begin
        in_first_r <= 1'b0;
        bad_pkt_r  <= ~len_ok_s;
      end
    end
  end

  nukv_fifogen #(.DATA_SIZE(DATA_W + 1), .ADDR_BITS(FIFO_ADDR_BITS)) u_pay_fifo (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata({bus.pkt_rx_TLAST, bus.pkt_rx_TDATA}), .s_axis_tvalid(keep_beat_s),
    .s_axis_tready(pay_in_rdy_s),
    .m_axis_tdata(pay_head_s), .m_axis_tvalid(pay_valid_s), .m_axis_tready(pay_pop_s)
  );

  nukv_fifogen #(.DATA_SIZE(32), .ADDR_BITS(FIFO_ADDR_BITS)) u_meta_fifo (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(bus.pkt_rx_TUSER), .s_axis_tvalid(meta_push_s), .s_axis_tready(meta_in_rdy_s),
    .m_axis_tdata(meta_head_s), .m_axis_tvalid(meta_valid_s),
    .m_axis_tready(bus.m_axis_tx_metadata_TREADY & rst_n)
  );

  nukv_fifogen #(.DATA_SIZE(16), .ADDR_BITS(FIFO_ADDR_BITS)) u_len_fifo (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(rx_len_s), .s_axis_tvalid(meta_push_s), .s_axis_tready(len_in_rdy_s),
    .m_axis_tdata(len_head_s), .m_axis_tvalid(len_valid_s), .m_axis_tready(len_pop_s)
  );

  nukv_fifogen #(.DATA_SIZE(1), .ADDR_BITS(FIFO_ADDR_BITS)) u_status_fifo (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(bus.s_axis_tx_status_TDATA[STATUS_ERR_BIT]),
    .s_axis_tvalid(bus.s_axis_tx_status_TVALID), .s_axis_tready(st_in_rdy_s),
    .m_axis_tdata(st_head_s), .m_axis_tvalid(st_valid_s), .m_axis_tready(st_pop_s)
  );

  assign bus.s_axis_tx_status_TREADY = rst_n & st_in_rdy_s;
  assign pay_last_s                  = pay_head_s[DATA_W];

  // Egress state register and length latched at the IDLE decision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      len_r   <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      if (len_pop_s) len_r <= len_head_s;
    end
  end

  // Egress next state and FIFO pops; payload moves only once its status is known.
  always_comb begin
    state_nxt_s  = state_r;
    st_pop_s     = 1'b0;
    len_pop_s    = 1'b0;
    pay_pop_s    = 1'b0;
    data_valid_s = 1'b0;
    tx_inc_s     = 1'b0;
    drop_inc_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (st_valid_s & len_valid_s & pay_valid_s) begin
          st_pop_s    = 1'b1;
          len_pop_s   = 1'b1;
          state_nxt_s = st_head_s ? DROP : SEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        data_valid_s = pay_valid_s;
        if (pay_valid_s & bus.m_axis_tx_data_TREADY) begin
          pay_pop_s   = 1'b1;
          tx_inc_s    = pay_last_s;
          state_nxt_s = pay_last_s ? IDLE : SEND;
        end else begin
          state_nxt_s = SEND;
        end
      end
      DROP: begin
        if (pay_valid_s) begin
          pay_pop_s   = 1'b1;
          drop_inc_s  = pay_last_s;
          state_nxt_s = pay_last_s ? IDLE : DROP;
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output drive, forced to zero while reset is held.
  always_comb begin
    bus.m_axis_tx_data_TVALID     = 1'b0;
    bus.m_axis_tx_data_TDATA      = {DATA_W{1'b0}};
    bus.m_axis_tx_data_TKEEP      = {BYTES{1'b0}};
    bus.m_axis_tx_data_TLAST      = 1'b0;
    bus.m_axis_tx_metadata_TVALID = 1'b0;
    bus.m_axis_tx_metadata_TDATA  = 32'd0;
    if (rst_n) begin
      bus.m_axis_tx_data_TVALID     = data_valid_s;
      bus.m_axis_tx_data_TDATA      = pay_head_s[DATA_W-1:0];
      bus.m_axis_tx_data_TKEEP      = pay_last_s ? last_keep(len_r[REM_W-1:0]) : {BYTES{1'b1}};
      bus.m_axis_tx_data_TLAST      = pay_last_s;
      bus.m_axis_tx_metadata_TVALID = meta_valid_s;
      bus.m_axis_tx_metadata_TDATA  = meta_head_s;
    end else begin
      bus.m_axis_tx_data_TVALID     = 1'b0;
      bus.m_axis_tx_metadata_TVALID = 1'b0;
    end
  end

  // Statistics counters, wrapping naturally at 2**32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_pkt_cnt   <= 32'd0;
      drop_pkt_cnt <= 32'd0;
      bad_len_cnt  <= 32'd0;
    end else begin
      if (tx_inc_s)                          tx_pkt_cnt   <= tx_pkt_cnt + 32'd1;
      if (drop_inc_s)                        drop_pkt_cnt <= drop_pkt_cnt + 32'd1;
      if (toss_beat_s & bus.pkt_rx_TLAST)    bad_len_cnt  <= bad_len_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_pkt_sender_mb.sv
// Directed bench for pkt_sender_mb: vector table plus multi-cycle corner sequences.
module tb_pkt_sender_mb;
  localparam int DW = 512;
  localparam int BY = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] tx_pkt_cnt, drop_pkt_cnt, bad_len_cnt;

  always #5 clk = ~clk;

  pkt_sender_mb_if #(.DATA_W(DW)) bus ();

  pkt_sender_mb #(.DATA_W(DW), .MAX_BEATS(16), .FIFO_ADDR_BITS(5), .STATUS_ERR_BIT(62)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .tx_pkt_cnt(tx_pkt_cnt), .drop_pkt_cnt(drop_pkt_cnt), .bad_len_cnt(bad_len_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [BY-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    logic [15:0]   len;
    logic [15:0]   sess;
    int            nb;
    bit            err;
    bit            bad;
    logic [31:0]   exp_meta;
    logic [BY-1:0] exp_klast;
    int            exp_out;
  } vec_t;

  localparam logic [BY-1:0] ALL1 = {BY{1'b1}};

  beat_t       exp_q[$];
  beat_t       act_q[$];
  logic [31:0] meta_q[$];
  int          stamp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rx_acc = 0;
  int dvalid_cycles = 0;
  bit hold = 1'b0;
  bit rnd = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int tag, input int b);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = 32'(tag * 65536 + b * 256 + i);
    return d;
  endfunction

  // Data-side TREADY: held low, random, or always high.
  initial begin
    bus.m_axis_tx_data_TREADY = 1'b0;
    forever begin
      @(negedge clk);
      bus.m_axis_tx_data_TREADY = hold ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Monitor samples one time unit before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (rst_n) begin
        if (bus.pkt_rx_TVALID && bus.pkt_rx_TREADY) rx_acc++;
        if (bus.m_axis_tx_metadata_TVALID && bus.m_axis_tx_metadata_TREADY)
          meta_q.push_back(bus.m_axis_tx_metadata_TDATA);
        if (bus.m_axis_tx_data_TVALID) dvalid_cycles++;
        if (bus.m_axis_tx_data_TVALID && bus.m_axis_tx_data_TREADY) begin
          act_q.push_back({bus.m_axis_tx_data_TDATA, bus.m_axis_tx_data_TKEEP, bus.m_axis_tx_data_TLAST});
          stamp_q.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_pkt(input logic [15:0] len, input logic [15:0] sess, input int nb,
                          input int tag, input logic [BY-1:0] klast, input bit expect_out);
    for (int b = 0; b < nb; b++) begin
      bit hs;
      int w;
      hs = 1'b0;
      w = 0;
      @(negedge clk);
      bus.pkt_rx_TVALID = 1'b1;
      bus.pkt_rx_TDATA  = pat(tag, b);
      bus.pkt_rx_TUSER  = {len, sess};
      bus.pkt_rx_TLAST  = (b == nb - 1);
      do begin
        #1 hs = bus.pkt_rx_TREADY;
        @(posedge clk);
        if (!hs) begin
          w++;
          @(negedge clk);
        end
      end while (!hs && w < 400);
      if (!hs) begin
        checks++;
        failures++;
        $display("FAIL rx_timeout: got no TREADY expected accept tag=%0d beat=%0d", tag, b);
        bus.pkt_rx_TVALID = 1'b0;
        return;
      end
      if (expect_out)
        exp_q.push_back({pat(tag, b), (b == nb - 1) ? klast : ALL1, 1'(b == nb - 1)});
    end
    #1 bus.pkt_rx_TVALID = 1'b0;
  endtask

  task automatic push_status(input bit err);
    bit hs;
    int w;
    hs = 1'b0;
    w = 0;
    @(negedge clk);
    bus.s_axis_tx_status_TVALID = 1'b1;
    bus.s_axis_tx_status_TDATA  = {1'b0, err, 62'h1234};
    do begin
      #1 hs = bus.s_axis_tx_status_TREADY;
      @(posedge clk);
      if (!hs) begin
        w++;
        @(negedge clk);
      end
    end while (!hs && w < 400);
    if (!hs) begin
      checks++;
      failures++;
      $display("FAIL status_timeout: got no TREADY expected accept");
    end
    #1 bus.s_axis_tx_status_TVALID = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int w;
    w = 0;
    while (act_q.size() < n && w < budget) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic compare_beats(input string name);
    beat_t e, a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) begin
        failures++;
        $display("FAIL %s_missing: got no beat expected last=%0b keep=%h", name, e.last, e.keep);
      end else begin
        a = act_q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL %s_beat: got last=%0b keep=%h d0=%h expected last=%0b keep=%h d0=%h",
                   name, a.last, a.keep, a.data[63:0], e.last, e.keep, e.data[63:0]);
        end
      end
    end
    chk({name, "_extra"}, act_q.size(), 0);
    act_q.delete();
  endtask

  vec_t vt[7];

  initial begin
    int base;
    int m0;
    int dv0;
    bit seen;

    vt[0] = '{16'd64,   16'd7, 1, 1'b0, 1'b0, 32'h00400007, ALL1,             1};
    vt[1] = '{16'd130,  16'd7, 3, 1'b0, 1'b0, 32'h00820007, 64'h3,            3};
    vt[2] = '{16'd1,    16'd7, 1, 1'b0, 1'b0, 32'h00010007, 64'h1,            1};
    vt[3] = '{16'd128,  16'd7, 2, 1'b1, 1'b0, 32'h00800007, ALL1,             0};
    vt[4] = '{16'd100,  16'd3, 2, 1'b0, 1'b0, 32'h00640003, 64'hF_FFFF_FFFF,  2};
    vt[5] = '{16'd0,    16'd5, 2, 1'b0, 1'b1, 32'h0,        ALL1,             0};
    vt[6] = '{16'd1025, 16'd5, 3, 1'b0, 1'b1, 32'h0,        ALL1,             0};

    bus.pkt_rx_TVALID = 1'b0;
    bus.pkt_rx_TDATA  = {DW{1'b0}};
    bus.pkt_rx_TUSER  = 32'd0;
    bus.pkt_rx_TLAST  = 1'b0;
    bus.s_axis_tx_status_TVALID = 1'b0;
    bus.s_axis_tx_status_TDATA  = 64'd0;
    bus.m_axis_tx_metadata_TREADY = 1'b1;

    repeat (3) @(negedge clk);
    #2;
    chk("rst_rx_tready", bus.pkt_rx_TREADY, 0);
    chk("rst_status_tready", bus.s_axis_tx_status_TREADY, 0);
    chk("rst_meta_tvalid", bus.m_axis_tx_metadata_TVALID, 0);
    chk("rst_data_tvalid", bus.m_axis_tx_data_TVALID, 0);
    chk("rst_counters", {tx_pkt_cnt, drop_pkt_cnt | bad_len_cnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      m0  = meta_q.size();
      dv0 = dvalid_cycles;
      if (!vt[i].bad) push_status(vt[i].err);
      send_pkt(vt[i].len, vt[i].sess, vt[i].nb, 100 + i, vt[i].exp_klast, vt[i].exp_out > 0);
      repeat (30) @(negedge clk);
      chk($sformatf("vec%0d_meta_count", i), meta_q.size() - m0, vt[i].bad ? 0 : 1);
      if (meta_q.size() > m0)
        chk($sformatf("vec%0d_meta_value", i), meta_q[meta_q.size() - 1], vt[i].exp_meta);
      chk($sformatf("vec%0d_data_valid_cycles", i), dvalid_cycles - dv0, vt[i].exp_out);
      compare_beats($sformatf("vec%0d", i));
    end
    chk("tx_pkt_cnt_table", tx_pkt_cnt, 4);
    chk("drop_pkt_cnt_table", drop_pkt_cnt, 1);
    chk("bad_len_cnt_table", bad_len_cnt, 2);

    // Delayed status with random egress back-pressure.
    rnd  = 1'b1;
    base = rx_acc;
    fork
      begin
        for (int p = 0; p < 3; p++) send_pkt(16'd1024, 16'd9, 16, 200 + p, ALL1, 1'b1);
      end
      begin
        repeat (45) @(negedge clk);
        #2;
        chk("stall_rx_beats", rx_acc - base, 32);
        chk("stall_rx_tready", bus.pkt_rx_TREADY, 0);
        repeat (5) @(negedge clk);
        for (int p = 0; p < 3; p++) push_status(1'b0);
      end
    join
    wait_beats(48, 1500);
    rnd = 1'b0;
    compare_beats("stall");
    chk("tx_pkt_cnt_stall", tx_pkt_cnt, 7);

    // Reset while a 4-beat packet is in SEND.
    hold = 1'b1;
    push_status(1'b0);
    send_pkt(16'd256, 16'd4, 4, 300, ALL1, 1'b0);
    seen = 1'b0;
    for (int w = 0; w < 50 && !seen; w++) begin
      @(negedge clk);
      #2 seen = bus.m_axis_tx_data_TVALID;
    end
    chk("mid_send_reached", seen, 1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("mrst_data_tvalid", bus.m_axis_tx_data_TVALID, 0);
    chk("mrst_data_tkeep", bus.m_axis_tx_data_TKEEP, 0);
    chk("mrst_meta_tvalid", bus.m_axis_tx_metadata_TVALID, 0);
    chk("mrst_rx_tready", bus.pkt_rx_TREADY, 0);
    chk("mrst_status_tready", bus.s_axis_tx_status_TREADY, 0);
    chk("mrst_tx_cnt", tx_pkt_cnt, 0);
    chk("mrst_drop_bad_cnt", {drop_pkt_cnt, bad_len_cnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hold  = 1'b0;
    act_q.delete();
    exp_q.delete();
    meta_q.delete();
    push_status(1'b0);
    send_pkt(16'd200, 16'd4, 4, 310, 64'hFF, 1'b1);
    wait_beats(4, 100);
    compare_beats("post_rst");
    chk("post_rst_tx_cnt", tx_pkt_cnt, 1);
    chk("post_rst_meta_count", meta_q.size(), 1);
    if (meta_q.size() > 0) chk("post_rst_meta_value", meta_q[0], 32'h00C80004);

    // Back-to-back maximum-length packets.
    for (int p = 0; p < 4; p++) push_status(1'b0);
    base = stamp_q.size();
    for (int p = 0; p < 4; p++) send_pkt(16'd1024, 16'd2, 16, 400 + p, ALL1, 1'b1);
    wait_beats(64, 500);
    chk("thru_beat_count", stamp_q.size() - base, 64);
    if (stamp_q.size() >= base + 64) begin
      chk("thru_burst", stamp_q[base + 15] - stamp_q[base], 15);
      chk("thru_span", stamp_q[base + 63] - stamp_q[base], 66);
    end
    compare_beats("thru");
    chk("tx_pkt_cnt_final", tx_pkt_cnt, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
